poly_midi_player: RTL



---
 rtl/poly_midi_player_pkg.sv | 53 +++++
 rtl/midi_msg_parser.sv | 98 +++++++++
 rtl/poly_midi_player_wave.sv | 36 +++
 rtl/poly_midi_player.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/poly_midi_player_pkg.sv
// Shared MIDI definitions: status codes, waveform and parser encodings, and
// the note-to-phase-increment table used by every voice.
package poly_midi_player_pkg;

  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] NOTE_OFF = 4'h8;

  typedef enum logic [1:0] {
    WAVE_SAW      = 2'd0,
    WAVE_TRIANGLE = 2'd1,
    WAVE_PULSE    = 2'd2,
    WAVE_SINE     = 2'd3
  } wave_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_D1 = 3'd1,
    WAIT_D2 = 3'd2,
    SKIP1   = 3'd3,
    SKIP2   = 3'd4
  } parser_state_t;

  // Offset-binary zero level for a sample of the given width.
  function automatic logic [31:0] midpoint(input int bits);
    return 32'd1 << (bits - 1);
  endfunction

  // Top octave (notes 120..131) as 24-bit phase increments at 50 MHz;
  // lower octaves are the same values shifted right once per octave.
  function automatic logic [15:0] midi_note_to_tone_freq(input logic [6:0] note);
    logic [15:0] base;
    logic [3:0]  octave;
    logic [3:0]  semis;
    octave = 4'(note / 7'd12);
    semis  = 4'(note % 7'd12);
    case (semis)
      4'd0:    base = 16'd2809;
      4'd1:    base = 16'd2976;
      4'd2:    base = 16'd3153;
      4'd3:    base = 16'd3341;
      4'd4:    base = 16'd3539;
      4'd5:    base = 16'd3750;
      4'd6:    base = 16'd3973;
      4'd7:    base = 16'd4209;
      4'd8:    base = 16'd4459;
      4'd9:    base = 16'd4724;
      4'd10:   base = 16'd5005;
      default: base = 16'd5303;
    endcase
    return base >> (4'd10 - octave);
  endfunction

endpackage

// File: rtl/midi_msg_parser.sv
// MIDI byte-stream parser with running status and channel filter; emits
// one-cycle note_on / note_off pulses carrying the note number.
module midi_msg_parser
  import poly_midi_player_pkg::*;
#(
  parameter int OMNI         = 1,
  parameter int MIDI_CHANNEL = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] midi_data,
  input  logic       midi_valid,
  output logic       note_on,
  output logic       note_off,
  output logic [6:0] note
);

  parser_state_t state_reg, state_next;
  logic [7:0] status_reg, status_next;
  logic [6:0] d1_reg, d1_next;
  logic [6:0] note_reg, note_next;
  logic       note_on_reg, note_on_next;
  logic       note_off_reg, note_off_next;
  logic       chan_ok;

  function automatic parser_state_t restart_state(input logic [7:0] status);
    case (status[7:4])
      NOTE_ON, NOTE_OFF: return WAIT_D1;
      4'hC, 4'hD:        return SKIP1;
      default:           return SKIP2;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      status_reg   <= '0;
      d1_reg       <= '0;
      note_reg     <= '0;
      note_on_reg  <= 1'b0;
      note_off_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      status_reg   <= status_next;
      d1_reg       <= d1_next;
      note_reg     <= note_next;
      note_on_reg  <= note_on_next;
      note_off_reg <= note_off_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    status_next   = status_reg;
    d1_next       = d1_reg;
    note_next     = note_reg;
    note_on_next  = 1'b0;
    note_off_next = 1'b0;
    chan_ok       = (OMNI != 0) || (status_reg[3:0] == 4'(MIDI_CHANNEL));
    if (midi_valid) begin
      if (midi_data[7]) begin
        // Realtime bytes (F8..FF) pass through without touching the parse.
        if (midi_data < 8'hF0) begin
          status_next = midi_data;
          state_next  = restart_state(midi_data);
        end else if (midi_data < 8'hF8) begin
          status_next = '0;
          state_next  = IDLE;
        end
      end else begin
        case (state_reg)
          WAIT_D1: begin
            d1_next    = midi_data[6:0];
            state_next = WAIT_D2;
          end
          WAIT_D2: begin
            state_next = restart_state(status_reg);
            note_next  = d1_reg;
            if (chan_ok) begin
              if (status_reg[7:4] == NOTE_ON && midi_data != 8'h00)
                note_on_next = 1'b1;
              else if (status_reg[7:4] == NOTE_ON || status_reg[7:4] == NOTE_OFF)
                note_off_next = 1'b1;
            end
          end
          SKIP2:   state_next = SKIP1;
          SKIP1:   state_next = restart_state(status_reg);
          default: state_next = state_reg;
        endcase
      end
    end
  end

  assign note_on  = note_on_reg;
  assign note_off = note_off_reg;
  assign note     = note_reg;

endmodule

// File: rtl/poly_midi_player_wave.sv
// Per-voice waveform generator: saw, triangle, pulse and a parabolic sine
// approximation, selected combinationally from the voice phase.
module poly_midi_player_wave
  import poly_midi_player_pkg::*;
#(
  parameter int OUTPUT_BITS     = 16,
  parameter int PULSEWIDTH_BITS = 12
) (
  input  logic [OUTPUT_BITS-1:0]     phase,
  input  logic [1:0]                 wave_sel,
  input  logic [PULSEWIDTH_BITS-1:0] pulse_width,
  output logic [OUTPUT_BITS-1:0]     sample
);

  localparam int H = OUTPUT_BITS - 1;
  localparam logic [OUTPUT_BITS-1:0] MID = OUTPUT_BITS'(midpoint(OUTPUT_BITS));

  logic [H-1:0] half_pos;
  logic [H-1:0] arch;

  // x*(1-x) over each half period, scaled so the peak stays just below MID.
  assign half_pos = phase[H-1:0];
  assign arch = H'(({{H{1'b0}}, half_pos} * {{H{1'b0}}, ~half_pos}) >> (OUTPUT_BITS - 3));

  always_comb begin
    sample = phase;
    case (wave_t'(wave_sel))
      WAVE_SAW:      sample = phase;
      WAVE_TRIANGLE: sample = {phase[H-1:0], 1'b0} ^ {OUTPUT_BITS{phase[H]}};
      WAVE_PULSE:    sample = (phase[H -: PULSEWIDTH_BITS] < pulse_width) ? '1 : '0;
      WAVE_SINE:     sample = phase[H] ? (MID - OUTPUT_BITS'(arch)) : (MID + OUTPUT_BITS'(arch));
      default:       sample = phase;
    endcase
  end

endmodule

// File: rtl/poly_midi_player.sv
// Polyphonic MIDI player: parser, voice allocation with stealing, per-voice
// phase accumulators and waveform generators, and a strobed averaging mixer.
module poly_midi_player
  import poly_midi_player_pkg::*;
#(
  parameter int VOICES           = 4,
  parameter int OUTPUT_BITS      = 16,
  parameter int ACCUMULATOR_BITS = 24,
  parameter int FREQ_SHIFT       = 2,
  parameter int SAMPLE_DIV       = 1,
  parameter int OMNI             = 1,
  parameter int MIDI_CHANNEL     = 0,
  parameter int PULSEWIDTH_BITS  = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 midi_data,
  input  logic                       midi_valid,
  input  logic [1:0]                 wave_sel,
  input  logic [PULSEWIDTH_BITS-1:0] pulse_width,
  output logic [OUTPUT_BITS-1:0]     sound_data,
  output logic                       sound_valid,
  output logic [VOICES-1:0]          voice_active
);

  localparam int LOG_V = $clog2(VOICES);
  localparam int PTR_W = (VOICES > 1) ? LOG_V : 1;
  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int SUM_W = OUTPUT_BITS + LOG_V;
  localparam logic [OUTPUT_BITS-1:0] MID = OUTPUT_BITS'(midpoint(OUTPUT_BITS));

  logic                        ev_on, ev_off;
  logic [6:0]                  ev_note;
  logic [ACCUMULATOR_BITS-1:0] acc_reg [VOICES];
  logic [ACCUMULATOR_BITS-1:0] inc_reg [VOICES];
  logic [6:0]                  note_reg [VOICES];
  logic [VOICES-1:0]           active_reg;
  logic [PTR_W-1:0]            steal_ptr_reg, steal_ptr_next;
  logic [DIV_W-1:0]            div_reg;
  logic [OUTPUT_BITS-1:0]      sound_reg;
  logic                        valid_reg;
  logic                        strobe;
  logic [VOICES-1:0]           match, sel;
  logic [ACCUMULATOR_BITS-1:0] inc_new;
  logic [OUTPUT_BITS-1:0]      wave_out [VOICES];
  logic [OUTPUT_BITS-1:0]      contrib [VOICES];
  logic [SUM_W-1:0]            sum;

  midi_msg_parser #(
    .OMNI         (OMNI),
    .MIDI_CHANNEL (MIDI_CHANNEL)
  ) u_parser (
    .clk        (clk),
    .rst        (rst),
    .midi_data  (midi_data),
    .midi_valid (midi_valid),
    .note_on    (ev_on),
    .note_off   (ev_off),
    .note       (ev_note)
  );

  assign strobe  = (div_reg == '0);
  assign inc_new = ACCUMULATOR_BITS'(midi_note_to_tone_freq(ev_note)) << FREQ_SHIFT;

  genvar gi;
  generate
    for (gi = 0; gi < VOICES; gi++) begin : g_voice
      assign match[gi] = active_reg[gi] && (note_reg[gi] == ev_note);

      poly_midi_player_wave #(
        .OUTPUT_BITS     (OUTPUT_BITS),
        .PULSEWIDTH_BITS (PULSEWIDTH_BITS)
      ) u_wave (
        .phase       (acc_reg[gi][ACCUMULATOR_BITS-1 -: OUTPUT_BITS]),
        .wave_sel    (wave_sel),
        .pulse_width (pulse_width),
        .sample      (wave_out[gi])
      );

      assign contrib[gi] = active_reg[gi] ? wave_out[gi] : MID;
    end
  endgenerate

  // Retrigger a matching voice, else the lowest free voice, else steal.
  always_comb begin
    sel            = '0;
    steal_ptr_next = steal_ptr_reg;
    if (ev_on) begin
      if (|match) begin
        for (int i = VOICES - 1; i >= 0; i--)
          if (match[i]) begin
            sel    = '0;
            sel[i] = 1'b1;
          end
      end else if (!(&active_reg)) begin
        for (int i = VOICES - 1; i >= 0; i--)
          if (!active_reg[i]) begin
            sel    = '0;
            sel[i] = 1'b1;
          end
      end else begin
        sel[steal_ptr_reg] = 1'b1;
        steal_ptr_next = (steal_ptr_reg == PTR_W'(VOICES - 1)) ? '0 : steal_ptr_reg + PTR_W'(1);
      end
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < VOICES; i++)
      sum = sum + SUM_W'(contrib[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < VOICES; i++) begin
        acc_reg[i]  <= '0;
        inc_reg[i]  <= '0;
        note_reg[i] <= '0;
      end
      active_reg    <= '0;
      steal_ptr_reg <= '0;
      div_reg       <= '0;
      sound_reg     <= MID;
      valid_reg     <= 1'b0;
    end else begin
      for (int i = 0; i < VOICES; i++) begin
        if (sel[i]) begin
          // Allocation takes precedence over a coincident strobe.
          acc_reg[i]    <= '0;
          inc_reg[i]    <= inc_new;
          note_reg[i]   <= ev_note;
          active_reg[i] <= 1'b1;
        end else begin
          if (strobe && active_reg[i])
            acc_reg[i] <= acc_reg[i] + inc_reg[i];
          if (ev_off && match[i])
            active_reg[i] <= 1'b0;
        end
      end
      steal_ptr_reg <= steal_ptr_next;
      div_reg       <= (div_reg == DIV_W'(SAMPLE_DIV - 1)) ? '0 : div_reg + DIV_W'(1);
      valid_reg     <= strobe;
      if (strobe)
        sound_reg <= OUTPUT_BITS'(sum >> LOG_V);
    end
  end

  assign sound_data   = sound_reg;
  assign sound_valid  = valid_reg;
  assign voice_active = active_reg;

endmodule
